clk_meter: RTL and testbench

CLK_METER -- requirements
Module: clk_meter

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/clk_meter_sync_edge_det.sv | 32 +++
 rtl/clk_meter.sv | 150 +++++++++++++++
 tb/tb_clk_meter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and default sizing for the clock/waveform meter.
// Holds the level FSM encoding so the top and the bench agree on it.
package clk_meter_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/clk_meter_sync_edge_det.sv
// Brings an asynchronous input into the clk domain and flags its edges.
// rise/fall are single-cycle, derived from the synchronized level s.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   s_d;

  // Only chain[0] may go metastable; later stages give it time to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      s_d   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      s_d   <= chain[SYNC_STAGES-1];
    end
  end

  assign s    = chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clk_meter.sv
// Measures high time, low time and period of sig_in in clk cycles, plus the
// delay from a phase_arm pulse to the next rising edge of sig_in.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  input  logic             phase_arm,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic             phase_valid,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_MAX - CNT_ONE;

  state_t           state;
  logic [CNT_W-1:0] lvl_cnt;
  logic [CNT_W-1:0] pend_high;
  logic [CNT_W-1:0] ph_cnt;
  logic             ph_active;
  logic             s_unused;
  logic             rise;
  logic             fall;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_in),
    .s    (s_unused),
    .rise (rise),
    .fall (fall)
  );

  // Level FSM. A counter about to hit all-ones means the input stopped
  // toggling, so the period is abandoned and stuck is raised instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lvl_cnt    <= '0;
      pend_high  <= '0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (rise) begin
        stuck <= 1'b0;
      end
      if (!en) begin
        state   <= IDLE;
        lvl_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            lvl_cnt <= '0;
            if (rise) begin
              state   <= HIGH;
              lvl_cnt <= CNT_ONE;
            end
          end
          HIGH: begin
            if (fall) begin
              pend_high <= lvl_cnt;
              state     <= LOW;
              lvl_cnt   <= CNT_ONE;
            end else if (lvl_cnt == CNT_SAT) begin
              stuck   <= 1'b1;
              state   <= IDLE;
              lvl_cnt <= '0;
            end else begin
              lvl_cnt <= lvl_cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt   <= pend_high;
              low_cnt    <= lvl_cnt;
              period_cnt <= {1'b0, pend_high} + {1'b0, lvl_cnt};
              meas_valid <= 1'b1;
              state      <= HIGH;
              lvl_cnt    <= CNT_ONE;
            end else if (lvl_cnt == CNT_SAT) begin
              stuck   <= 1'b1;
              state   <= IDLE;
              lvl_cnt <= '0;
            end else begin
              lvl_cnt <= lvl_cnt + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            lvl_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Phase counter runs independently of the FSM; a rise coincident with
  // the arm reports zero, and a fresh arm always restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt      <= '0;
      ph_active   <= 1'b0;
      phase_cnt   <= '0;
      phase_valid <= 1'b0;
    end else begin
      phase_valid <= 1'b0;
      if (!en) begin
        ph_active <= 1'b0;
      end else if (phase_arm) begin
        if (rise) begin
          phase_cnt   <= '0;
          phase_valid <= 1'b1;
          ph_active   <= 1'b0;
          ph_cnt      <= '0;
        end else begin
          ph_cnt    <= CNT_ONE;
          ph_active <= 1'b1;
        end
      end else if (ph_active) begin
        if (rise) begin
          phase_cnt   <= ph_cnt;
          phase_valid <= 1'b1;
          ph_active   <= 1'b0;
        end else if (ph_cnt == CNT_MAX) begin
          ph_active <= 1'b0;
        end else begin
          ph_cnt <= ph_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// Directed bench for clk_meter: duty/period measurement, phase timing,
// stuck detection, reset and enable behaviour, with hand-computed results.
module tb_clk_meter;
  import clk_meter_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sig_in;
  logic             phase_arm;
  logic             meas_valid;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W:0]   period_cnt;
  logic             phase_valid;
  logic [CNT_W-1:0] phase_cnt;
  logic             stuck;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mv_count = 0;
  int pv_count = 0;
  int last_mv  = 0;
  int prev_mv  = 0;
  int mv_snap;
  int pv_snap;

  clk_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sig_in      (sig_in),
    .phase_arm   (phase_arm),
    .meas_valid  (meas_valid),
    .high_cnt    (high_cnt),
    .low_cnt     (low_cnt),
    .period_cnt  (period_cnt),
    .phase_valid (phase_valid),
    .phase_cnt   (phase_cnt),
    .stuck       (stuck)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    cyc++;
    if (meas_valid === 1'b1) begin
      mv_count++;
      prev_mv = last_mv;
      last_mv = cyc;
    end
    if (phase_valid === 1'b1) begin
      pv_count++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input int hi, input int lo, input int periods);
    for (int p = 0; p < periods; p++) begin
      sig_in = 1'b1;
      cycles(hi);
      sig_in = 1'b0;
      cycles(lo);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    sig_in    = 1'b0;
    phase_arm = 1'b0;
    cycles(3);
    check_output("rst_meas_valid", 32'(meas_valid), 32'd0);
    check_output("rst_high_cnt", 32'(high_cnt), 32'd0);
    check_output("rst_period_cnt", 32'(period_cnt), 32'd0);
    check_output("rst_phase_valid", 32'(phase_valid), 32'd0);
    check_output("rst_stuck", 32'(stuck), 32'd0);
    check_output("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    cycles(2);

    // 30% duty, 10-cycle period: five rises give four complete periods.
    mv_snap = mv_count;
    apply_stimulus(3, 7, 5);
    check_output("d30_pulses", 32'(mv_count - mv_snap), 32'd4);
    check_output("d30_interval", 32'(last_mv - prev_mv), 32'd10);
    check_output("d30_high", 32'(high_cnt), 32'd3);
    check_output("d30_low", 32'(low_cnt), 32'd7);
    check_output("d30_period", 32'(period_cnt), 32'd10);

    // 50% duty; the first rise here closes the last 3/7 period.
    mv_snap = mv_count;
    apply_stimulus(5, 5, 4);
    check_output("d50_pulses", 32'(mv_count - mv_snap), 32'd4);
    check_output("d50_interval", 32'(last_mv - prev_mv), 32'd10);
    check_output("d50_high", 32'(high_cnt), 32'd5);
    check_output("d50_low", 32'(low_cnt), 32'd5);
    check_output("d50_period", 32'(period_cnt), 32'd10);

    // Arm at T, sig_in sampled high at T+5, result visible after T+7.
    pv_snap   = pv_count;
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    cycles(4);
    sig_in = 1'b1;
    cycles(2);
    check_output("ph_early", 32'(phase_valid), 32'd0);
    cycles(1);
    check_output("ph_valid", 32'(phase_valid), 32'd1);
    check_output("ph_cnt", 32'(phase_cnt), 32'd7);
    cycles(1);
    check_output("ph_one_pulse", 32'(phase_valid), 32'd0);
    check_output("ph_pulses", 32'(pv_count - pv_snap), 32'd1);

    // Arm landing on the same cycle as the rise reports zero.
    sig_in = 1'b0;
    cycles(4);
    sig_in = 1'b1;
    cycles(2);
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    check_output("ph_coinc_valid", 32'(phase_valid), 32'd1);
    check_output("ph_coinc_cnt", 32'(phase_cnt), 32'd0);

    // Re-arm three cycles in restarts the count from the second arm.
    sig_in = 1'b0;
    cycles(4);
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    cycles(2);
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    cycles(1);
    sig_in = 1'b1;
    cycles(3);
    check_output("ph_rearm_valid", 32'(phase_valid), 32'd1);
    check_output("ph_rearm_cnt", 32'(phase_cnt), 32'd4);

    // Hold high long enough for the HIGH counter to saturate.
    sig_in = 1'b0;
    cycles(5);
    sig_in = 1'b1;
    cycles(4);
    check_output("stuck_before", 32'(stuck), 32'd0);
    mv_snap = mv_count;
    cycles(65540);
    check_output("stuck_set", 32'(stuck), 32'd1);
    check_output("stuck_no_meas", 32'(mv_count - mv_snap), 32'd0);
    sig_in = 1'b0;
    cycles(5);
    check_output("stuck_fall_keeps", 32'(stuck), 32'd1);
    sig_in = 1'b1;
    cycles(2);
    check_output("stuck_pre_rise", 32'(stuck), 32'd1);
    cycles(1);
    check_output("stuck_cleared", 32'(stuck), 32'd0);
    mv_snap = mv_count;
    cycles(1);
    sig_in = 1'b0;
    cycles(6);
    sig_in = 1'b1;
    cycles(1);
    check_output("restart_no_early", 32'(mv_count - mv_snap), 32'd0);
    cycles(2);
    check_output("restart_meas", 32'(meas_valid), 32'd1);
    check_output("restart_high", 32'(high_cnt), 32'd4);
    check_output("restart_low", 32'(low_cnt), 32'd6);
    check_output("restart_period", 32'(period_cnt), 32'd10);

    // Reset in LOW with a phase measurement pending.
    cycles(1);
    sig_in = 1'b0;
    cycles(3);
    check_output("pre_rst_state", 32'(dut.state), 32'(LOW));
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    pv_snap = pv_count;
    mv_snap = mv_count;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_output("mid_rst_high", 32'(high_cnt), 32'd0);
    check_output("mid_rst_low", 32'(low_cnt), 32'd0);
    check_output("mid_rst_period", 32'(period_cnt), 32'd0);
    check_output("mid_rst_phase_cnt", 32'(phase_cnt), 32'd0);
    check_output("mid_rst_state", 32'(dut.state), 32'(IDLE));
    cycles(3);
    sig_in = 1'b1;
    cycles(5);
    check_output("mid_rst_no_meas", 32'(mv_count - mv_snap), 32'd0);
    check_output("mid_rst_no_phase", 32'(pv_count - pv_snap), 32'd0);

    // Establish known results, then disable and toggle at another duty.
    sig_in = 1'b0;
    cycles(4);
    apply_stimulus(2, 8, 3);
    check_output("pre_en_high", 32'(high_cnt), 32'd2);
    check_output("pre_en_low", 32'(low_cnt), 32'd8);
    en        = 1'b0;
    mv_snap   = mv_count;
    pv_snap   = pv_count;
    phase_arm = 1'b1;
    cycles(1);
    phase_arm = 1'b0;
    apply_stimulus(6, 4, 3);
    check_output("en0_no_meas", 32'(mv_count - mv_snap), 32'd0);
    check_output("en0_no_phase", 32'(pv_count - pv_snap), 32'd0);
    check_output("en0_high_held", 32'(high_cnt), 32'd2);
    check_output("en0_low_held", 32'(low_cnt), 32'd8);
    check_output("en0_period_held", 32'(period_cnt), 32'd10);
    check_output("en0_state", 32'(dut.state), 32'(IDLE));

    en      = 1'b1;
    mv_snap = mv_count;
    apply_stimulus(6, 4, 3);
    check_output("en1_pulses", 32'(mv_count - mv_snap), 32'd2);
    check_output("en1_high", 32'(high_cnt), 32'd6);
    check_output("en1_low", 32'(low_cnt), 32'd4);
    check_output("en1_period", 32'(period_cnt), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
